pipe_skid_stage: RTL

- Parametrised pipeline register for inter-stage boundaries (fetch/decode, decode/execute, ...). It generalises the fixed-width, always-advancing stage register.
- Valid/ready handshake with a 2-entry skid buffer. Downstream stalls never need a combinational path back upstream; full throughput is kept.
- Synchronous flush for branch mispredict / exception squash.
- Instruction, PC and any sideband are packed by the instantiating stage into one data bus.

---
 rtl/pipe_skid_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and synchronous flush.
// Optional saturating downstream-stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              state, state_nxt;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              accept, pop;
    logic              load_main, main_from_skid, load_skid;

    // Handshake outputs depend on state only, so a downstream stall never ripples upstream combinationally.
    assign out_valid = (state != EMPTY);
    assign in_ready  = (state != TWO);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign occupancy = state;
    assign out_data  = main_q;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (!rst) state <= EMPTY;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        state_nxt      = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end
            end
            TWO: begin
                if (pop) begin
                    main_from_skid = 1'b1;
                    state_nxt      = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Squash overrides everything: incoming data is dropped, a same-cycle pop still happened downstream.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main      = 1'b0;
            main_from_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: payload registers are reset too, so out_data reads zero out of reset.
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)           main_q <= in_data;
            else if (main_from_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

`ifdef PIPE_SKID_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q;

    // Saturating count of cycles the head entry waited on downstream; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
